// File: rtl/pipe_ctrl_n_if.sv
// Handshake bundle between the pipeline stages and the pipeline controller.
// The master side is the core (stage requests, redirects); the slave side is
// pipe_ctrl_n, which returns the hold/bubble vectors and status.
interface pipe_ctrl_n_if #(
   parameter int STAGES = 6,
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32
);
   localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;

   // requests from the stages
   logic [STAGES-1:0] stallreq;
   logic              cnt_req;
   logic [SEL_W-1:0]  cnt_stage;
   logic [CNT_W-1:0]  cnt_len;
   logic              flush_req;
   logic [31:0]       flush_pc;

   // controls back to the stages
   logic [STAGES-1:0] stall;
   logic [STAGES-1:0] bubble;
   logic              flush;
   logic [31:0]       new_pc;
   logic              busy;
   logic [PERF_W-1:0] stall_cycles;
   logic              wdog_trip;

   modport master (
      output stallreq, cnt_req, cnt_stage, cnt_len, flush_req, flush_pc,
      input  stall, bubble, flush, new_pc, busy, stall_cycles, wdog_trip
   );

   modport slave (
      input  stallreq, cnt_req, cnt_stage, cnt_len, flush_req, flush_pc,
      output stall, bubble, flush, new_pc, busy, stall_cycles, wdog_trip
   );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Parametrised pipeline controller: merges per-stage stall requests into a
// monotone stall vector plus a single bubble bit, runs counted multi-cycle
// stalls, registers flush/redirect, counts stalled cycles and watches for
// pipelines that stay stalled too long.
module pipe_ctrl_n #(
   parameter int STAGES = 6,
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32,
   parameter int WDOG   = 1024
) (
   input logic          clk,
   input logic          rst,
   pipe_ctrl_n_if.slave pc
);
   localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int RUN_W = (WDOG > 1) ? $clog2(WDOG + 1) : 1;
   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(WDOG);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [SEL_W-1:0]  cnt_stage_q;
   logic              busy_q;
   logic              flush_q;
   logic [31:0]       new_pc_q;

   logic [STAGES-1:0] cnt_vec;
   logic [STAGES-1:0] eff;
   logic [STAGES-1:0] stall_c;
   logic [STAGES-1:0] bubble_c;
   logic              seen;

   logic [PERF_W-1:0] perf_q;
   logic [RUN_W-1:0]  run;
   logic              trip_q;

   function automatic logic [STAGES-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [STAGES-1:0] o;
      for (int i = 0; i < STAGES; i++) o[i] = (s == SEL_W'(i));
      return o;
   endfunction

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == '1) ? v : v + PERF_W'(1);
   endfunction

   // Stall contribution of the counted-stall machinery: the latched owner while
   // counting, or the requesting stage in the request cycle itself.
   always_comb begin
      cnt_vec = '0;
      if (state == COUNT)
         cnt_vec = onehot(cnt_stage_q);
      else if (pc.cnt_req && (pc.cnt_len != '0))
         cnt_vec = onehot(pc.cnt_stage);
   end

   assign eff = pc.stallreq | cnt_vec;

   // Hold every stage at or below the highest requester; the stage just above
   // it latches a NOP. Reset and flush clear both vectors.
   always_comb begin
      stall_c  = '0;
      bubble_c = '0;
      seen     = 1'b0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         seen       = seen | eff[i];
         stall_c[i] = seen;
      end
      for (int i = 1; i < STAGES; i++)
         bubble_c[i] = stall_c[i-1] & ~stall_c[i];
      if (rst || flush_q) begin
         stall_c  = '0;
         bubble_c = '0;
      end
   end

   // Counted-stall FSM with registered busy, flush pulse and redirect target;
   // a flush request aborts any counted stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
      end else begin
         flush_q <= pc.flush_req;
         if (pc.flush_req) begin
            new_pc_q <= pc.flush_pc;
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (pc.cnt_req && (pc.cnt_len > CNT_W'(1))) begin
                     state       <= COUNT;
                     cnt         <= pc.cnt_len - CNT_W'(1);
                     cnt_stage_q <= pc.cnt_stage;
                     busy_q      <= 1'b1;
                  end
               end
               COUNT: begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating stalled-cycle counter and consecutive-stall watchdog; the
   // watchdog only reports, it never touches the stall vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
         run    <= '0;
         trip_q <= 1'b0;
      end else if (stall_c[0]) begin
         perf_q <= sat_inc(perf_q);
         if (run != RUN_LIM) run <= run + RUN_W'(1);
         if ((WDOG != 0) && (run >= RUN_LIM - RUN_W'(1))) trip_q <= 1'b1;
      end else begin
         run <= '0;
      end
   end

   assign pc.stall        = stall_c;
   assign pc.bubble       = bubble_c;
   assign pc.flush        = flush_q;
   assign pc.new_pc       = new_pc_q;
   assign pc.busy         = busy_q;
   assign pc.stall_cycles = perf_q;
   assign pc.wdog_trip    = trip_q;
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: two instances share one stimulus stream, one with a
// short watchdog (8) and one with a 4-bit perf counter to reach saturation.
// Every cycle both are compared against a cycle-level behavioural model.
module tb_pipe_ctrl_n;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipe_ctrl_n_if #(.STAGES(6), .CNT_W(6), .PERF_W(32)) ifa ();
   pipe_ctrl_n_if #(.STAGES(6), .CNT_W(6), .PERF_W(4))  ifb ();

   assign ifb.stallreq  = ifa.stallreq;
   assign ifb.cnt_req   = ifa.cnt_req;
   assign ifb.cnt_stage = ifa.cnt_stage;
   assign ifb.cnt_len   = ifa.cnt_len;
   assign ifb.flush_req = ifa.flush_req;
   assign ifb.flush_pc  = ifa.flush_pc;

   pipe_ctrl_n #(.STAGES(6), .CNT_W(6), .PERF_W(32), .WDOG(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .pc  (ifa)
   );

   pipe_ctrl_n #(.STAGES(6), .CNT_W(6), .PERF_W(4), .WDOG(1024)) dut_b (
      .clk (clk),
      .rst (rst),
      .pc  (ifb)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state
   int          rem = 0;        // cycles of counted stall still to come
   int          own = 0;
   logic        m_flush = 1'b0;
   logic [31:0] m_pc = '0;
   longint      perf_a = 0;
   longint      perf_b = 0;
   int          run = 0;
   logic        trip_a = 1'b0;
   logic        trip_b = 1'b0;
   bit          pending = 1'b0;

   // inputs of the current cycle
   logic        s_rst;
   logic [5:0]  s_sr;
   logic        s_cr;
   logic [2:0]  s_cs;
   logic [5:0]  s_cl;
   logic        s_fr;
   logic [31:0] s_fp;
   logic        s_st0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [5:0] cv, eff, es, eb;
      int k;
      cv = '0;
      if (rem > 0) cv = 6'(1) << own;
      else if (s_cr && s_cl != 0) cv = 6'(1) << s_cs;
      eff = s_sr | cv;
      k = -1;
      for (int i = 0; i < 6; i++) if (eff[i]) k = i;
      es = '0;
      eb = '0;
      if (k >= 0) begin
         es = 6'((1 << (k + 1)) - 1);
         if (k < 5) eb = 6'(1 << (k + 1));
      end
      if (s_rst || m_flush) begin
         es = '0;
         eb = '0;
      end
      s_st0 = es[0];
      chk("stall_a",  64'(ifa.stall),  64'(es));
      chk("bubble_a", 64'(ifa.bubble), 64'(eb));
      chk("stall_b",  64'(ifb.stall),  64'(es));
      chk("flush",    64'(ifa.flush),  64'(m_flush));
      chk("new_pc",   64'(ifa.new_pc), 64'(m_pc));
      chk("busy",     64'(ifa.busy),   64'(rem > 0));
      chk("perf_a",   64'(ifa.stall_cycles), 64'(perf_a));
      chk("perf_b",   64'(ifb.stall_cycles), 64'(perf_b));
      chk("wdog_a",   64'(ifa.wdog_trip), 64'(trip_a));
      chk("wdog_b",   64'(ifb.wdog_trip), 64'(trip_b));
   endtask

   task automatic model_edge();
      if (s_rst) begin
         rem = 0; m_flush = 1'b0; m_pc = '0;
         perf_a = 0; perf_b = 0; run = 0; trip_a = 1'b0; trip_b = 1'b0;
      end else begin
         if (s_st0) begin
            if (perf_a < 64'hFFFF_FFFF) perf_a++;
            if (perf_b < 15) perf_b++;
            run++;
         end else begin
            run = 0;
         end
         if (run >= 8) trip_a = 1'b1;
         if (run >= 1024) trip_b = 1'b1;
         m_flush = s_fr;
         if (s_fr) m_pc = s_fp;
         if (s_fr) rem = 0;
         else if (rem > 0) rem--;
         else if (s_cr && s_cl >= 2) begin
            rem = int'(s_cl) - 1;
            own = int'(s_cs);
         end
      end
   endtask

   // Drive one cycle's inputs, then compare every output against the model.
   task automatic apply(input logic r, input logic [5:0] sr, input logic cr,
                        input logic [2:0] cs, input logic [5:0] cl,
                        input logic fr, input logic [31:0] fp);
      if (pending) begin
         @(posedge clk);
         model_edge();
      end
      @(negedge clk);
      rst = r; ifa.stallreq = sr; ifa.cnt_req = cr; ifa.cnt_stage = cs;
      ifa.cnt_len = cl; ifa.flush_req = fr; ifa.flush_pc = fp;
      s_rst = r; s_sr = sr; s_cr = cr; s_cs = cs; s_cl = cl; s_fr = fr; s_fp = fp;
      #1;
      model_check();
      pending = 1'b1;
   endtask

   task automatic idle();
      apply(1'b0, 6'b0, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      apply(1'b1, 6'b0, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      ifa.stallreq = '0; ifa.cnt_req = 1'b0; ifa.cnt_stage = '0;
      ifa.cnt_len = '0; ifa.flush_req = 1'b0; ifa.flush_pc = '0;
      repeat (2) @(posedge clk);

      // reset state
      do_reset();
      idle();
      chk("rst_busy", 64'(ifa.busy), 64'd0);
      chk("rst_perf", 64'(ifa.stall_cycles), 64'd0);

      // request merge
      apply(1'b0, 6'b000100, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      chk("merge2_stall",  64'(ifa.stall),  64'b000111);
      chk("merge2_bubble", 64'(ifa.bubble), 64'b001000);
      apply(1'b0, 6'b100000, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      chk("merge5_stall",  64'(ifa.stall),  64'b111111);
      chk("merge5_bubble", 64'(ifa.bubble), 64'b000000);

      // counted stall, length 5 on EX
      do_reset();
      apply(1'b0, 6'b0, 1'b1, 3'd3, 6'd5, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) idle();
         chk("cnt_stall",  64'(ifa.stall),  64'b001111);
         chk("cnt_bubble", 64'(ifa.bubble), 64'b010000);
         chk("cnt_busy",   64'(ifa.busy),   64'(i >= 1));
      end
      idle();
      chk("cnt_done_stall", 64'(ifa.stall), 64'd0);
      chk("cnt_done_busy",  64'(ifa.busy),  64'd0);
      chk("cnt_perf",       64'(ifa.stall_cycles), 64'd5);
      apply(1'b0, 6'b0, 1'b1, 3'd3, 6'd1, 1'b0, 32'h0);
      chk("len1_stall", 64'(ifa.stall), 64'b001111);
      idle();
      chk("len1_busy",  64'(ifa.busy),  64'd0);
      chk("len1_stall_after", 64'(ifa.stall), 64'd0);

      // flush mid-count
      do_reset();
      apply(1'b0, 6'b0, 1'b1, 3'd3, 6'd20, 1'b0, 32'h0);
      idle();
      idle();
      apply(1'b0, 6'b0, 1'b0, 3'd0, 6'd0, 1'b1, 32'hBFC0_0380);
      idle();
      chk("fl_flush", 64'(ifa.flush),  64'd1);
      chk("fl_pc",    64'(ifa.new_pc), 64'hBFC0_0380);
      chk("fl_stall", 64'(ifa.stall),  64'd0);
      chk("fl_busy",  64'(ifa.busy),   64'd0);
      idle();
      chk("fl_drop",  64'(ifa.flush),  64'd0);
      chk("fl_stall2", 64'(ifa.stall), 64'd0);
      chk("fl_pc_hold", 64'(ifa.new_pc), 64'hBFC0_0380);

      // overlap of counted stall and a higher request
      do_reset();
      apply(1'b0, 6'b0, 1'b1, 3'd3, 6'd5, 1'b0, 32'h0);
      apply(1'b0, 6'b010000, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      chk("ov_stall",  64'(ifa.stall),  64'b011111);
      chk("ov_bubble", 64'(ifa.bubble), 64'b100000);
      idle();
      chk("ov_revert", 64'(ifa.stall),  64'b001111);

      // watchdog: 7 stalled + 1 clear does not trip, 8 stalled does
      do_reset();
      repeat (7) apply(1'b0, 6'b000100, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      idle();
      chk("wd_no_trip", 64'(ifa.wdog_trip), 64'd0);
      repeat (8) apply(1'b0, 6'b000100, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      chk("wd_pre_trip", 64'(ifa.wdog_trip), 64'd0);
      idle();
      chk("wd_trip", 64'(ifa.wdog_trip), 64'd1);
      idle();
      chk("wd_sticky", 64'(ifa.wdog_trip), 64'd1);

      // reset mid-count
      do_reset();
      apply(1'b0, 6'b0, 1'b1, 3'd3, 6'd20, 1'b0, 32'h0);
      idle();
      idle();
      do_reset();
      chk("rc_stall_in_rst", 64'(ifa.stall), 64'd0);
      idle();
      chk("rc_busy",  64'(ifa.busy),  64'd0);
      chk("rc_stall", 64'(ifa.stall), 64'd0);
      chk("rc_perf",  64'(ifa.stall_cycles), 64'd0);

      // perf counter saturation
      do_reset();
      repeat (20) apply(1'b0, 6'b000001, 1'b0, 3'd0, 6'd0, 1'b0, 32'h0);
      idle();
      chk("sat_perf_b", 64'(ifb.stall_cycles), 64'd15);
      chk("sat_perf_a", 64'(ifa.stall_cycles), 64'd20);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic        r, cr, fr;
         logic [5:0]  sr, cl;
         logic [2:0]  cs;
         logic [31:0] fp;
         r  = ($urandom_range(0, 199) == 0);
         sr = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         cr = ($urandom_range(0, 7) == 0);
         cs = 3'($urandom_range(0, 5));
         cl = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 8));
         fr = ($urandom_range(0, 19) == 0);
         fp = 32'($urandom);
         apply(r, sr, cr, cs, cl, fr, fp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
